// File: rtl/alu_seq_unit.sv
// Handshaked ALU with a registered result, six-way branch compare and an iterative
// shift-add multiply. Upstream stalls while a multiply runs or a result is unconsumed.
module alu_seq_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       br_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             branching
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand, mplier, acc;
  logic [SHAMT_W-1:0] cnt;
  logic               br_pend;

  logic [WIDTH-1:0]   alu_res, acc_sum;
  logic [SHAMT_W-1:0] shamt;
  logic               br_res, accept, mul_done;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (state == MUL) && (cnt == '0);
  assign shamt    = b[SHAMT_W-1:0];
  assign acc_sum  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    unique case (ALUOp)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_res = 1'b0;
    unique case (br_op)
      3'b000:  br_res = (a == b);
      3'b001:  br_res = (a != b);
      3'b100:  br_res = $signed(a) <  $signed(b);
      3'b101:  br_res = $signed(a) >= $signed(b);
      3'b110:  br_res = a <  b;
      3'b111:  br_res = a >= b;
      default: br_res = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      br_pend   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      branching <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept && ALUOp == OP_MUL) begin
          state   <= MUL;
          mcand   <= a;
          mplier  <= b;
          acc     <= '0;
          cnt     <= SHAMT_W'(WIDTH-1);
          br_pend <= br_res;
        end
        MUL: begin
          // one multiplier bit per cycle, LSB first; only the low WIDTH bits survive
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept && ALUOp != OP_MUL) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        branching <= br_res;
        out_valid <= 1'b1;
      end else if (mul_done) begin
        result    <= acc_sum;
        zero      <= (acc_sum == '0);
        branching <= br_pend;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: reset, arithmetic, compares, shifts, multiply, backpressure.
module tb_alu_seq_unit;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [63:0] a = 0, b = 0, result;
  logic [3:0]  ALUOp = 0;
  logic [2:0]  br_op = 0;
  logic        zero, branching;
  int total = 0, bad = 0;

  alu_seq_unit #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUOp(ALUOp), .br_op(br_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .branching(branching)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] br, input logic [63:0] x, input logic [63:0] y);
    a = x; b = y; ALUOp = op; br_op = br; in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    out_ready = 0;
    issue(4'b0010, 3'b001, 64'd5, 64'd3);
    total++; if (out_valid !== 1'b1 || result !== 64'd8) begin bad++;
      $display("FAIL pre_reset_add ov=%b res=%h want ov=1 res=8", out_valid, result); end
    rst_n = 0; #1;
    total++; if (out_valid !== 1'b0 || result !== 64'd0 || zero !== 1'b1 || branching !== 1'b0) begin bad++;
      $display("FAIL reset_state ov=%b res=%h z=%b br=%b want 0/0/1/0", out_valid, result, zero, branching); end
    tick(); tick();
    rst_n = 1; out_ready = 1; #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_release ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
  endtask

  task automatic test_arith();
    issue(4'b0010, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    total++; if (out_valid !== 1'b1 || result !== 64'd0 || zero !== 1'b1 || branching !== 1'b0) begin bad++;
      $display("FAIL add_wrap ov=%b res=%h z=%b br=%b want 1/0/1/0", out_valid, result, zero, branching); end
    issue(4'b0110, 3'b001, 64'd5, 64'd7);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE || zero !== 1'b0 || branching !== 1'b1) begin bad++;
      $display("FAIL sub res=%h z=%b br=%b want fffffffffffffffe/0/1", result, zero, branching); end
    issue(4'b1100, 3'b010, 64'hF0F0, 64'h0F00);
    total++; if (result !== 64'hFFFF_FFFF_FFFF_000F || branching !== 1'b0) begin bad++;
      $display("FAIL nor res=%h br=%b want ffffffffffff000f/0", result, branching); end
    issue(4'b0000, 3'b011, 64'hFF00, 64'h0FF0);
    total++; if (result !== 64'h0F00) begin bad++;
      $display("FAIL and res=%h want 0f00", result); end
    issue(4'b0001, 3'b000, 64'hFF00, 64'h0FF0);
    total++; if (result !== 64'hFFF0) begin bad++;
      $display("FAIL or res=%h want fff0", result); end
    issue(4'b1111, 3'b000, 64'h1234, 64'h1234);
    total++; if (result !== 64'd0 || zero !== 1'b1 || branching !== 1'b1) begin bad++;
      $display("FAIL undef_op res=%h z=%b br=%b want 0/1/1", result, zero, branching); end
  endtask

  task automatic test_compare();
    issue(4'b0111, 3'b100, 64'h8000_0000_0000_0000, 64'd1);
    total++; if (result !== 64'd1 || branching !== 1'b1) begin bad++;
      $display("FAIL slt_blt res=%h br=%b want 1/1", result, branching); end
    issue(4'b1000, 3'b110, 64'h8000_0000_0000_0000, 64'd1);
    total++; if (result !== 64'd0 || zero !== 1'b1 || branching !== 1'b0) begin bad++;
      $display("FAIL sltu_bltu res=%h z=%b br=%b want 0/1/0", result, zero, branching); end
    issue(4'b0010, 3'b111, 64'h8000_0000_0000_0000, 64'd1);
    total++; if (branching !== 1'b1) begin bad++;
      $display("FAIL bgeu br=%b want 1", branching); end
    issue(4'b0010, 3'b101, 64'h8000_0000_0000_0000, 64'd1);
    total++; if (branching !== 1'b0) begin bad++;
      $display("FAIL bge br=%b want 0", branching); end
  endtask

  task automatic test_shift();
    issue(4'b0101, 3'b000, 64'h8000_0000_0000_0000, 64'h43);
    total++; if (result !== 64'hF000_0000_0000_0000) begin bad++;
      $display("FAIL sra res=%h want f000000000000000", result); end
    issue(4'b0100, 3'b000, 64'h8000_0000_0000_0000, 64'h43);
    total++; if (result !== 64'h1000_0000_0000_0000) begin bad++;
      $display("FAIL srl res=%h want 1000000000000000", result); end
    issue(4'b0011, 3'b000, 64'd1, 64'd63);
    total++; if (result !== 64'h8000_0000_0000_0000) begin bad++;
      $display("FAIL sll res=%h want 8000000000000000", result); end
  endtask

  task automatic run_mul(input logic [63:0] x, input logic [63:0] y, input logic [63:0] want, input string nm);
    bit stall_ok = 1;
    issue(4'b1001, 3'b001, x, y);
    for (int k = 0; k < 64; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) stall_ok = 0;
      if (k < 63) tick();
    end
    total++; if (!stall_ok) begin bad++;
      $display("FAIL %s_stall ir/ov not held low for 64 cycles", nm); end
    tick();
    total++; if (out_valid !== 1'b1 || result !== want || branching !== (x != y)) begin bad++;
      $display("FAIL %s ov=%b res=%h br=%b want 1/%h/%b", nm, out_valid, result, branching, want, x != y); end
  endtask

  task automatic test_mul();
    bit seen = 0;
    run_mul(64'd123456789, 64'd1000, 64'd123456789000, "mul_dec");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "mul_neg");
    issue(4'b1001, 3'b000, 64'd7, 64'd9);
    for (int k = 0; k < 29; k++) tick();
    rst_n = 0; tick(); tick(); rst_n = 1;
    for (int k = 0; k < 70; k++) begin
      if (out_valid !== 1'b0) seen = 1;
      tick();
    end
    total++; if (seen || in_ready !== 1'b1) begin bad++;
      $display("FAIL mul_reset_abort ov_seen=%b ir=%b want 0/1", seen, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[4];
    logic [63:0] held = 0;
    bit          was_stall = 0;
    int          nin = 0, nout = 0, cyc = 0;
    logic [3:0]  pat = 4'b1001;
    for (int i = 0; i < 4; i++) exp_q[i] = 64'(100 * (i + 1) + 11 * (i + 1));
    ALUOp = 4'b0010; br_op = 3'b000;
    while (nout < 4 && cyc < 40) begin
      out_ready = pat[3 - (cyc % 4)];
      in_valid  = (nin < 4);
      a = 64'(100 * (nin + 1)); b = 64'(11 * (nin + 1));
      #1;
      if (was_stall) begin
        total++; if (out_valid !== 1'b1 || result !== held) begin bad++;
          $display("FAIL hold cyc=%0d ov=%b res=%h want 1/%h", cyc, out_valid, result, held); end
      end
      if (out_ready && nin < 4) begin
        total++; if (in_ready !== 1'b1) begin bad++;
          $display("FAIL throughput cyc=%0d ir=%b want 1", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        total++; if (result !== exp_q[nout]) begin bad++;
          $display("FAIL b2b_result idx=%0d res=%h want %h", nout, result, exp_q[nout]); end
        nout++;
      end
      was_stall = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) nin++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0; out_ready = 1; #1;
    total++; if (nout != 4 || out_valid !== 1'b0) begin bad++;
      $display("FAIL b2b_count got=%0d ov=%b want 4/0", nout, out_valid); end
  endtask

  initial begin
    tick(); tick();
    rst_n = 1; #1;
    total++; if (out_valid !== 1'b0 || result !== 64'd0 || zero !== 1'b1 || in_ready !== 1'b1) begin bad++;
      $display("FAIL init_reset ov=%b res=%h z=%b ir=%b", out_valid, result, zero, in_ready); end
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_mul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
